inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   IF stage of the 5-stage RV32I pipeline. Holds the PC and fetches one 32-bit
//   instruction per fetch as four byte reads from the byte-wide memory controller
//   port. Assembles the bytes little-endian and presents if_pc/if_inst to the
//   IF/ID register. Raises if_stall_req to ctrl while a fetch is incomplete.
//   Redirects on branch_flag_i from EX.
// PARAMETERS
//   RESET_PC  32'h0  PC value loaded on reset
// PORTS
//   clk              in   1          system clock; all state changes on posedge
//   rst              in   1          synchronous, active-high reset
//   stall_sign       in   `StallBus  ctrl stall vector; bit1 = hold IF stage
//   branch_flag_i    in   1          1-cycle redirect pulse from EX
//   branch_target_i  in   32         redirect PC, 4-byte aligned
//   mem_busy_i       in   1          port owned by MEM stage; IF request not granted
//   mem_data_i       in   8          read byte; valid the cycle after a grant
//   mem_req_o        out  1          IF byte-read request
//   mem_addr_o       out  32         byte address of request
//   if_pc            out  32         PC of assembled instruction, to IF/ID
//   if_inst          out  32         assembled instruction, to IF/ID
//   if_stall_req     out  1          fetch incomplete; ctrl stalls PC/IF/IF-ID
// BEHAVIOUR
//   - Reset (rst=1 at posedge): pc<=RESET_PC, req_idx<=0, rcv_idx<=0,
//     pend<=0, inst buffer<=0. Outputs forced while rst=1: mem_req_o=0,
//     if_stall_req=0. if_pc=RESET_PC and if_inst=0 after reset.
//   - State: req_idx 0..4 counts bytes requested; rcv_idx 0..4 counts bytes
//     received; pend=1 means a grant happened last cycle.
//   - Request: mem_req_o = !rst & req_idx<4 & !branch_flag_i.
//     mem_addr_o = pc + req_idx (32-bit add, wraps).
//   - Grant = mem_req_o & !mem_busy_i. On grant: req_idx++ and pend<=1.
//     Otherwise pend<=0. Busy holds the address unchanged; nothing is lost.
//   - Receive: if pend=1, mem_data_i -> buf byte[rcv_idx] (byte0 -> bits 7:0)
//     and rcv_idx++. Request and receive may occur in the same cycle.
//   - DONE = (rcv_idx==4). if_stall_req = !rst & !DONE.
//     if_inst = DONE ? buf : 0. if_pc = pc.
//   - Advance: in DONE with stall_sign[1]=0, pc<=pc+4 and req_idx, rcv_idx,
//     pend cleared; the next fetch issues the following cycle.
//     In DONE with stall_sign[1]=1: hold everything; no requests.
//   - Latency, no contention: request cycles 0..3, byte3 captured at the end
//     of cycle 4, DONE in cycle 5, next request in cycle 6.
//     Throughput is 6 cycles per instruction.
//   - Branch (branch_flag_i=1 in any state, regardless of stall_sign):
//     pc<=branch_target_i. req_idx, rcv_idx, pend cleared. buf<=0.
//     mem_req_o=0 that cycle. A byte in flight (pend=1) is discarded.
//     Fetch at the target starts the next cycle.
//   - Priority: rst > branch_flag_i > advance/hold > normal fetch.
//   - Reset mid-fetch: partial bytes are dropped; fetch restarts at RESET_PC.
// TESTING
//   1. Reset, mem[0..3]=13 05 10 00, busy=0 -> mem_addr_o 0,1,2,3 in cycles
//      0-3; cycle 5: if_inst=32'h00100513, if_pc=0, if_stall_req=0;
//      cycle 6: mem_addr_o=4.
//   2. As 1, mem_busy_i=1 in cycles 1-3 -> mem_addr_o stays 1 through cycle 3;
//      DONE in cycle 8 with if_inst=32'h00100513.
//   3. stall_sign[1]=1 for 4 cycles during DONE -> if_pc=0 and if_inst held,
//      mem_req_o=0; after release, next cycle mem_addr_o=4.
//   4. branch_flag_i=1, target 32'h100, in cycle 2 of a fetch -> mem_req_o=0
//      that cycle; the in-flight byte is not written; then addresses 0x100..0x103;
//      if_pc=32'h100 with inst from mem[0x100..0x103].
//   5. Branch during DONE with stall_sign[1]=1 -> redirect taken, if_inst=0,
//      if_stall_req=1 the next cycle.
//   6. rst=1 in cycle 3 of a fetch at pc=8 -> next cycle if_pc=RESET_PC,
//      if_inst=0; fetch restarts at RESET_PC with no stale bytes.

Source files
------------

// File: rtl/inst_fetch.sv
// IF stage of the 5-stage RV32I pipeline: fetches one 32-bit instruction as four
// little-endian byte reads from the byte-wide memory controller port.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_sign,
    input  logic               branch_flag_i,
    input  logic [31:0]        branch_target_i,
    input  logic               mem_busy_i,
    input  logic [7:0]         mem_data_i,
    output logic               mem_req_o,
    output logic [31:0]        mem_addr_o,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_inst,
    output logic               if_stall_req
);

    logic [31:0] pc;
    logic [31:0] inst_buf;
    logic [2:0]  req_idx;
    logic [2:0]  rcv_idx;
    logic        pend;
    logic        done;
    logic        grant;

    // Only the IF hold bit of the ctrl stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^{stall_sign[STALL_W-1:2], stall_sign[0]};

    assign done         = (rcv_idx == 3'd4);
    assign mem_req_o    = !rst && (req_idx < 3'd4) && !branch_flag_i;
    assign grant        = mem_req_o && !mem_busy_i;
    assign mem_addr_o   = pc + {29'd0, req_idx};
    assign if_stall_req = !rst && !done;
    assign if_inst      = done ? inst_buf : 32'd0;
    assign if_pc        = pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_idx  <= 3'd0;
            rcv_idx  <= 3'd0;
            pend     <= 1'b0;
            inst_buf <= 32'd0;
        end else if (branch_flag_i) begin
            // A byte still in flight belongs to the squashed fetch and is dropped.
            pc       <= branch_target_i;
            req_idx  <= 3'd0;
            rcv_idx  <= 3'd0;
            pend     <= 1'b0;
            inst_buf <= 32'd0;
        end else if (done) begin
            if (!stall_sign[1]) begin
                pc      <= pc + 32'd4;
                req_idx <= 3'd0;
                rcv_idx <= 3'd0;
                pend    <= 1'b0;
            end
        end else begin
            pend <= grant;
            if (grant) begin
                req_idx <= req_idx + 3'd1;
            end
            if (pend) begin
                case (rcv_idx[1:0])
                    2'd0:    inst_buf[7:0]   <= mem_data_i;
                    2'd1:    inst_buf[15:8]  <= mem_data_i;
                    2'd2:    inst_buf[23:16] <= mem_data_i;
                    default: inst_buf[31:24] <= mem_data_i;
                endcase
                rcv_idx <= rcv_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: per-cycle vector table plus a hand-written
// reset-mid-fetch sequence, against a byte-wide memory model with 1-cycle read latency.
module tb_inst_fetch;

    localparam logic [31:0] I1 = 32'h00100513;
    localparam logic [31:0] I2 = 32'h00500093;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_sign;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_busy_i;
    logic [7:0]  mem_data_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_stall_req;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:511];

    inst_fetch #(.RESET_PC(32'h0), .STALL_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_sign      (stall_sign),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_busy_i      (mem_busy_i),
        .mem_data_i      (mem_data_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_stall_req    (if_stall_req)
    );

    always #5 clk = ~clk;

    // Memory controller model: byte returned the cycle after a grant.
    always @(posedge clk) begin
        if (mem_req_o && !mem_busy_i)
            mem_data_i <= mem[mem_addr_o[8:0]];
    end

    typedef struct {
        logic        rst;
        logic        busy;
        logic        stl;
        logic        br;
        logic [31:0] tgt;
        logic        chk;    // compare addr/pc/inst (off while reset is applied)
        logic        req;
        logic [31:0] addr;
        logic        sreq;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    function automatic vec_t v(input logic r, input logic busy, input logic stl,
                               input logic br, input logic [31:0] tgt, input logic chk,
                               input logic req, input logic [31:0] addr, input logic sreq,
                               input logic [31:0] pc, input logic [31:0] inst);
        vec_t x;
        x.rst = r; x.busy = busy; x.stl = stl; x.br = br; x.tgt = tgt; x.chk = chk;
        x.req = req; x.addr = addr; x.sreq = sreq; x.pc = pc; x.inst = inst;
        return x;
    endfunction

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Called just after a posedge: drive, sample at the falling edge, move to next cycle.
    task automatic apply(input vec_t x, input int id);
        rst             = x.rst;
        mem_busy_i      = x.busy;
        stall_sign      = {4'b0, x.stl, 1'b0};
        branch_flag_i   = x.br;
        branch_target_i = x.tgt;
        @(negedge clk);
        check("mem_req_o", id, {31'd0, mem_req_o}, {31'd0, x.req});
        check("if_stall_req", id, {31'd0, if_stall_req}, {31'd0, x.sreq});
        if (x.chk) begin
            check("mem_addr_o", id, mem_addr_o, x.addr);
            check("if_pc", id, if_pc, x.pc);
            check("if_inst", id, if_inst, x.inst);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [$];

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 8'(a) ^ 8'h5A;
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[9'h100] = 8'h93; mem[9'h101] = 8'h00; mem[9'h102] = 8'h50; mem[9'h103] = 8'h00;

        rst = 1'b1; mem_busy_i = 1'b0; stall_sign = '0; branch_flag_i = 1'b0;
        branch_target_i = '0; mem_data_i = 8'h00;
        @(posedge clk);
        #1;

        // Uncontended fetch: addresses 0..3, DONE in cycle 5, next request in cycle 6.
        tbl.push_back(v(1,0,0,0,0,        0,0,0,    0,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,0,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,1,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,2,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,3,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,0,4,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,0,4,    0,0,    I1));
        tbl.push_back(v(0,0,0,0,0,        1,1,4,    1,4,    0));
        // Busy in cycles 1-3 holds address 1; DONE in cycle 8, then stalled 4 cycles.
        tbl.push_back(v(1,0,0,0,0,        0,0,0,    0,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,0,    1,0,    0));
        tbl.push_back(v(0,1,0,0,0,        1,1,1,    1,0,    0));
        tbl.push_back(v(0,1,0,0,0,        1,1,1,    1,0,    0));
        tbl.push_back(v(0,1,0,0,0,        1,1,1,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,1,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,2,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,3,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,0,4,    1,0,    0));
        tbl.push_back(v(0,0,1,0,0,        1,0,4,    0,0,    I1));
        tbl.push_back(v(0,0,1,0,0,        1,0,4,    0,0,    I1));
        tbl.push_back(v(0,0,1,0,0,        1,0,4,    0,0,    I1));
        tbl.push_back(v(0,0,1,0,0,        1,0,4,    0,0,    I1));
        tbl.push_back(v(0,0,0,0,0,        1,0,4,    0,0,    I1));
        tbl.push_back(v(0,0,0,0,0,        1,1,4,    1,4,    0));
        // Branch to 0x100 in cycle 2 with byte 1 in flight; then branch during stalled DONE.
        tbl.push_back(v(1,0,0,0,0,        0,0,0,    0,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,0,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,1,    1,0,    0));
        tbl.push_back(v(0,0,0,1,32'h100,  1,0,2,    1,0,    0));
        tbl.push_back(v(0,0,0,0,0,        1,1,32'h100,1,32'h100,0));
        tbl.push_back(v(0,0,0,0,0,        1,1,32'h101,1,32'h100,0));
        tbl.push_back(v(0,0,0,0,0,        1,1,32'h102,1,32'h100,0));
        tbl.push_back(v(0,0,0,0,0,        1,1,32'h103,1,32'h100,0));
        tbl.push_back(v(0,0,0,0,0,        1,0,32'h104,1,32'h100,0));
        tbl.push_back(v(0,0,1,1,0,        1,0,32'h104,0,32'h100,I2));
        tbl.push_back(v(0,0,0,0,0,        1,1,0,    1,0,    0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset in cycle 3 of a fetch at pc=8: partial bytes must not survive.
        apply(v(1,0,0,0,0,       0,0,0,  0,0,0), 100);
        apply(v(0,0,0,1,32'h8,   1,0,0,  1,0,0), 101);
        apply(v(0,0,0,0,0,       1,1,8,  1,8,0), 102);
        apply(v(0,0,0,0,0,       1,1,9,  1,8,0), 103);
        apply(v(0,0,0,0,0,       1,1,10, 1,8,0), 104);
        apply(v(1,0,0,0,0,       0,0,0,  0,0,0), 105);
        apply(v(0,0,0,0,0,       1,1,0,  1,0,0), 106);
        apply(v(0,0,0,0,0,       1,1,1,  1,0,0), 107);
        apply(v(0,0,0,0,0,       1,1,2,  1,0,0), 108);
        apply(v(0,0,0,0,0,       1,1,3,  1,0,0), 109);
        apply(v(0,0,0,0,0,       1,0,4,  1,0,0), 110);
        apply(v(0,0,0,0,0,       1,0,4,  0,0,I1), 111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
